// File: rtl/alu_if.sv
// Dispatch/result bundle between the reservation station (master) and the ALU (slave).
// The slave drives the CDB ALU lane and the branch resolution fields.
`ifndef ROBRange
`define ROBRange 3:0
`endif

interface alu_if;
  logic              ALU_enable;
  logic [5:0]        op_to_ALU;
  logic [31:0]       Vj_to_ALU;
  logic [31:0]       Vk_to_ALU;
  logic [31:0]       imm_to_ALU;
  logic [`ROBRange]  rdTag_to_ALU;
  logic [31:0]       pc_to_ALU;
  logic              B_ALU_valid;
  logic [31:0]       B_ALU_result;
  logic [`ROBRange]  B_ALU_rdTag;
  logic              ALU_jump;
  logic [31:0]       ALU_target;

  modport master (
    output ALU_enable, op_to_ALU, Vj_to_ALU, Vk_to_ALU, imm_to_ALU, rdTag_to_ALU, pc_to_ALU,
    input  B_ALU_valid, B_ALU_result, B_ALU_rdTag, ALU_jump, ALU_target
  );
  modport slave (
    input  ALU_enable, op_to_ALU, Vj_to_ALU, Vk_to_ALU, imm_to_ALU, rdTag_to_ALU, pc_to_ALU,
    output B_ALU_valid, B_ALU_result, B_ALU_rdTag, ALU_jump, ALU_target
  );
endinterface

// File: rtl/alu.sv
// Single-issue RV32I ALU: one-cycle latency, CDB broadcast, branch/jump resolution,
// and squash of the stale dispatch presented the cycle after a rollback.
`ifndef ROBRange
`define ROBRange 3:0
`endif
`ifndef OP_ADD
`define OP_ADD   6'd1
`define OP_SUB   6'd2
`define OP_AND   6'd3
`define OP_OR    6'd4
`define OP_XOR   6'd5
`define OP_SLL   6'd6
`define OP_SRL   6'd7
`define OP_SRA   6'd8
`define OP_SLT   6'd9
`define OP_SLTU  6'd10
`define OP_ADDI  6'd11
`define OP_ANDI  6'd12
`define OP_ORI   6'd13
`define OP_XORI  6'd14
`define OP_SLLI  6'd15
`define OP_SRLI  6'd16
`define OP_SRAI  6'd17
`define OP_SLTI  6'd18
`define OP_SLTIU 6'd19
`define OP_LUI   6'd20
`define OP_AUIPC 6'd21
`define OP_JAL   6'd22
`define OP_JALR  6'd23
`define OP_BEQ   6'd24
`define OP_BNE   6'd25
`define OP_BLT   6'd26
`define OP_BGE   6'd27
`define OP_BLTU  6'd28
`define OP_BGEU  6'd29
`endif

module alu (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic rollback,
  alu_if.slave bus
);
  logic [5:0]  op;
  logic [31:0] a, opb, imm, pc, pc4, pc_imm, res_c, tgt_c;
  logic [4:0]  sh;
  logic        lt_s, lt_u, eq, jmp_c, is_br, squash, accept;

  assign op     = bus.op_to_ALU;
  assign a      = bus.Vj_to_ALU;
  assign imm    = bus.imm_to_ALU;
  assign pc     = bus.pc_to_ALU;
  assign pc4    = pc + 32'd4;
  assign pc_imm = pc + imm;

  // Immediate forms swap in imm as operand 2; branches and R-type keep Vk.
  always_comb begin
    opb = bus.Vk_to_ALU;
    case (op)
      `OP_ADDI, `OP_ANDI, `OP_ORI, `OP_XORI, `OP_SLLI,
      `OP_SRLI, `OP_SRAI, `OP_SLTI, `OP_SLTIU: opb = imm;
      default: ;
    endcase
  end

  assign sh    = opb[4:0];
  assign lt_s  = $signed(a) < $signed(opb);
  assign lt_u  = a < opb;
  assign eq    = a == opb;
  assign is_br = (op >= `OP_BEQ) && (op <= `OP_BGEU);

  always_comb begin
    res_c = 32'd0;
    jmp_c = 1'b0;
    tgt_c = pc4;
    case (op)
      `OP_ADD,  `OP_ADDI:  res_c = a + opb;
      `OP_SUB:             res_c = a - opb;
      `OP_AND,  `OP_ANDI:  res_c = a & opb;
      `OP_OR,   `OP_ORI:   res_c = a | opb;
      `OP_XOR,  `OP_XORI:  res_c = a ^ opb;
      `OP_SLL,  `OP_SLLI:  res_c = a << sh;
      `OP_SRL,  `OP_SRLI:  res_c = a >> sh;
      `OP_SRA,  `OP_SRAI:  res_c = $unsigned($signed(a) >>> sh);
      `OP_SLT,  `OP_SLTI:  res_c = {31'd0, lt_s};
      `OP_SLTU, `OP_SLTIU: res_c = {31'd0, lt_u};
      `OP_LUI:             res_c = imm;
      `OP_AUIPC:           res_c = pc_imm;
      `OP_JAL: begin
        res_c = pc4;
        jmp_c = 1'b1;
        tgt_c = pc_imm;
      end
      `OP_JALR: begin
        res_c = pc4;
        jmp_c = 1'b1;
        tgt_c = (a + imm) & 32'hFFFF_FFFE;
      end
      `OP_BEQ:  jmp_c = eq;
      `OP_BNE:  jmp_c = ~eq;
      `OP_BLT:  jmp_c = lt_s;
      `OP_BGE:  jmp_c = ~lt_s;
      `OP_BLTU: jmp_c = lt_u;
      `OP_BGEU: jmp_c = ~lt_u;
      default: ;
    endcase
    if (is_br && jmp_c) tgt_c = pc_imm;
  end

  // squash covers the RS's un-updated dispatch in the cycle after rollback.
  assign accept = bus.ALU_enable && !rollback && !squash;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      squash           <= 1'b0;
      bus.B_ALU_valid  <= 1'b0;
      bus.B_ALU_result <= 32'd0;
      bus.B_ALU_rdTag  <= '0;
      bus.ALU_jump     <= 1'b0;
      bus.ALU_target   <= 32'd0;
    end else if (rdy) begin
      squash          <= rollback;
      bus.B_ALU_valid <= accept;
      if (accept) begin
        bus.B_ALU_result <= res_c;
        bus.B_ALU_rdTag  <= bus.rdTag_to_ALU;
        bus.ALU_jump     <= jmp_c;
        bus.ALU_target   <= tgt_c;
      end
    end
  end
endmodule

// File: tb/tb_alu.sv
// Directed plus randomized check of alu against a behavioural model of the
// RV32I ALU-class semantics and the rollback/stall/reset timing rules.
`ifndef ROBRange
`define ROBRange 3:0
`endif
`ifndef OP_ADD
`define OP_ADD   6'd1
`define OP_SUB   6'd2
`define OP_AND   6'd3
`define OP_OR    6'd4
`define OP_XOR   6'd5
`define OP_SLL   6'd6
`define OP_SRL   6'd7
`define OP_SRA   6'd8
`define OP_SLT   6'd9
`define OP_SLTU  6'd10
`define OP_ADDI  6'd11
`define OP_ANDI  6'd12
`define OP_ORI   6'd13
`define OP_XORI  6'd14
`define OP_SLLI  6'd15
`define OP_SRLI  6'd16
`define OP_SRAI  6'd17
`define OP_SLTI  6'd18
`define OP_SLTIU 6'd19
`define OP_LUI   6'd20
`define OP_AUIPC 6'd21
`define OP_JAL   6'd22
`define OP_JALR  6'd23
`define OP_BEQ   6'd24
`define OP_BNE   6'd25
`define OP_BLT   6'd26
`define OP_BGE   6'd27
`define OP_BLTU  6'd28
`define OP_BGEU  6'd29
`endif

module tb_alu;
  logic clk = 1'b0;
  logic rst, rdy, rollback;
  alu_if bus ();

  alu dut (.clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        jmp;
    logic [31:0] tgt;
  } out_t;

  int n_chk = 0;
  int n_fail = 0;

  // Expected architectural outputs and the model's notion of "dispatch blocked".
  logic              e_valid, e_jmp, m_block;
  logic [31:0]       e_res, e_tgt;
  logic [`ROBRange]  e_tag;

  function automatic out_t model(input logic [5:0] op, input logic [31:0] vj, vk, imm, pc);
    out_t o;
    logic [31:0] b;
    logic [4:0]  s;
    int          sj, sk, sb;
    logic        take;
    o.res = 32'd0; o.jmp = 1'b0; o.tgt = pc + 32'd4;
    b  = (op >= `OP_ADDI && op <= `OP_SLTIU) ? imm : vk;
    s  = b[4:0];
    sj = vj; sk = vk; sb = b;
    take = 1'b0;
    case (op)
      `OP_ADD, `OP_ADDI:   o.res = vj + b;
      `OP_SUB:             o.res = vj - vk;
      `OP_AND, `OP_ANDI:   o.res = vj & b;
      `OP_OR, `OP_ORI:     o.res = vj | b;
      `OP_XOR, `OP_XORI:   o.res = vj ^ b;
      `OP_SLL, `OP_SLLI:   o.res = vj << s;
      `OP_SRL, `OP_SRLI:   o.res = vj >> s;
      `OP_SRA, `OP_SRAI: begin
        o.res = vj >> s;
        if (vj[31]) o.res = o.res | ~(32'hFFFF_FFFF >> s);
      end
      `OP_SLT, `OP_SLTI:   o.res = (sj < sb) ? 32'd1 : 32'd0;
      `OP_SLTU, `OP_SLTIU: o.res = (vj < b) ? 32'd1 : 32'd0;
      `OP_LUI:             o.res = imm;
      `OP_AUIPC:           o.res = pc + imm;
      `OP_JAL:  begin o.res = pc + 32'd4; o.jmp = 1'b1; o.tgt = pc + imm; end
      `OP_JALR: begin o.res = pc + 32'd4; o.jmp = 1'b1; o.tgt = (vj + imm) & 32'hFFFF_FFFE; end
      default: begin
        if (op >= `OP_BEQ && op <= `OP_BGEU) begin
          case (op)
            `OP_BEQ:  take = (vj == vk);
            `OP_BNE:  take = (vj != vk);
            `OP_BLT:  take = (sj < sk);
            `OP_BGE:  take = (sj >= sk);
            `OP_BLTU: take = (vj < vk);
            default:  take = (vj >= vk);
          endcase
          o.jmp = take;
          if (take) o.tgt = pc + imm;
        end
      end
    endcase
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [5:0] op, input logic [31:0] vj, vk, imm,
                       input logic [`ROBRange] tag, input logic [31:0] pc);
    bus.ALU_enable = en; bus.op_to_ALU = op; bus.Vj_to_ALU = vj; bus.Vk_to_ALU = vk;
    bus.imm_to_ALU = imm; bus.rdTag_to_ALU = tag; bus.pc_to_ALU = pc;
  endtask

  task automatic check_outputs(input string tag, input logic all_fields);
    chk({tag, "_valid"}, {31'd0, bus.B_ALU_valid}, {31'd0, e_valid});
    if (e_valid || all_fields) begin
      chk({tag, "_result"}, bus.B_ALU_result, e_res);
      chk({tag, "_tag"}, {28'd0, bus.B_ALU_rdTag}, {28'd0, e_tag});
      chk({tag, "_jump"}, {31'd0, bus.ALU_jump}, {31'd0, e_jmp});
      chk({tag, "_target"}, bus.ALU_target, e_tgt);
    end
  endtask

  // Advance one clock: update expectations from the inputs in force at the edge.
  task automatic tick(input string tag);
    out_t o;
    if (rdy) begin
      if (bus.ALU_enable && !rollback && !m_block) begin
        o = model(bus.op_to_ALU, bus.Vj_to_ALU, bus.Vk_to_ALU, bus.imm_to_ALU, bus.pc_to_ALU);
        e_valid = 1'b1; e_res = o.res; e_jmp = o.jmp; e_tgt = o.tgt; e_tag = bus.rdTag_to_ALU;
      end else begin
        e_valid = 1'b0;
      end
      m_block = rollback;
    end
    @(posedge clk);
    #1;
    check_outputs(tag, 1'b0);
  endtask

  task automatic model_reset();
    e_valid = 1'b0; e_res = 32'd0; e_tag = '0; e_jmp = 1'b0; e_tgt = 32'd0; m_block = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, '0, 32'd0);
    model_reset();
    #12;
    check_outputs("reset", 1'b1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back ADD / SUB.
    drive(1'b1, `OP_ADD, 32'd7, 32'd5, 32'd0, 4'd3, 32'h0);
    tick("add");
    chk("add_const", bus.B_ALU_result, 32'd12);
    drive(1'b1, `OP_SUB, 32'd0, 32'd1, 32'd0, 4'd4, 32'h4);
    tick("sub");
    chk("sub_const", bus.B_ALU_result, 32'hFFFF_FFFF);

    drive(1'b1, `OP_SRA, 32'h8000_0000, 32'h24, 32'd0, 4'd1, 32'h8);
    tick("sra");
    chk("sra_const", bus.B_ALU_result, 32'hF800_0000);
    drive(1'b1, `OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'd2, 32'hC);
    tick("sltu");
    chk("sltu_const", bus.B_ALU_result, 32'd1);
    drive(1'b1, `OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'd2, 32'hC);
    tick("slt");
    chk("slt_const", bus.B_ALU_result, 32'd0);

    drive(1'b1, `OP_BLT, 32'hFFFF_FFFF, 32'd0, 32'h20, 4'd6, 32'h100);
    tick("blt");
    chk("blt_target_const", bus.ALU_target, 32'h120);
    drive(1'b1, `OP_BGEU, 32'hFFFF_FFFF, 32'd0, 32'h20, 4'd7, 32'h100);
    tick("bgeu");
    chk("bgeu_jump_const", {31'd0, bus.ALU_jump}, 32'd1);
    drive(1'b1, `OP_JALR, 32'h1001, 32'd0, 32'd2, 4'd8, 32'h40);
    tick("jalr");
    chk("jalr_target_const", bus.ALU_target, 32'h1002);
    chk("jalr_result_const", bus.B_ALU_result, 32'h44);
    drive(1'b1, 6'd63, 32'd9, 32'd9, 32'd9, 4'd9, 32'h200);
    tick("undef");

    // Rollback: dispatch held across t, t+1, t+2.
    drive(1'b1, `OP_ADDI, 32'd1, 32'd0, 32'd2, 4'd5, 32'h300);
    rollback = 1'b1;
    tick("rb_t");
    rollback = 1'b0;
    tick("rb_t1");
    tick("rb_t2");
    chk("rb_tag_const", {28'd0, bus.B_ALU_rdTag}, 32'd5);

    // Back-to-back rollbacks keep squash set.
    rollback = 1'b1; tick("rb2_a"); tick("rb2_b");
    rollback = 1'b0; tick("rb2_c"); tick("rb2_d");

    // rdy stall holds the pulse.
    drive(1'b1, `OP_XORI, 32'hA5A5_0000, 32'd0, 32'h0000_FFFF, 4'd10, 32'h400);
    tick("stall_acc");
    drive(1'b0, `OP_ADD, 32'd1, 32'd1, 32'd0, 4'd11, 32'h404);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) tick("stall_hold");
    chk("stall_valid_const", {31'd0, bus.B_ALU_valid}, 32'd1);
    rdy = 1'b1;
    tick("stall_release");

    // Async reset mid-broadcast.
    drive(1'b1, `OP_LUI, 32'd0, 32'd0, 32'hDEAD_B000, 4'd12, 32'h500);
    tick("pre_rst");
    drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, '0, 32'd0);
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs("async_rst", 1'b1);
    @(negedge clk); rst = 1'b0;
    drive(1'b1, `OP_AUIPC, 32'd0, 32'd0, 32'h1000, 4'd13, 32'h600);
    tick("post_rst");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] v1, v2, im;
      v1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom;
      v2 = ($urandom_range(0, 3) == 0) ? v1 : $urandom;
      im = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4095) : $urandom;
      drive($urandom_range(0, 3) != 0, 6'($urandom_range(0, 31)), v1, v2, im,
            4'($urandom_range(0, 15)), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      rdy = ($urandom_range(0, 7) != 0);
      rollback = ($urandom_range(0, 11) == 0);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu.md
# alu

Single-issue integer execution unit directly downstream of the reservation station. It accepts one dispatched RV32I ALU-class operation per cycle and computes the result with one cycle of latency. It broadcasts the result on the ALU lane of the common data bus (CDB), and reports branch/jump resolution to the ROB. It also squashes in-flight work on rollback, including the stale dispatch the reservation station still presents in the cycle after a rollback.

## Interface
Parameters: none; widths come from defines.v (`ROBRange`, op constants).

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global ready; low freezes all state
- rollback  in  1  ROB misprediction flush, sampled on clk
- ALU_enable  in  1  dispatch valid from RS
- op_to_ALU  in  6  operation code (defines.v constants)
- Vj_to_ALU  in  32  operand 1
- Vk_to_ALU  in  32  operand 2
- imm_to_ALU  in  32  sign-extended immediate
- rdTag_to_ALU  in  `ROBRange`  destination ROB tag
- pc_to_ALU  in  32  instruction PC
- B_ALU_valid  out  1  CDB result valid, one cycle per op
- B_ALU_result  out  32  rd write value
- B_ALU_rdTag  out  `ROBRange`  ROB tag of result
- ALU_jump  out  1  control transfer taken (valid with B_ALU_valid)
- ALU_target  out  32  next PC for branches/jumps

## Operation
- Each accepted op produces exactly one CDB broadcast; there is no backpressure.
- An op is accepted when rdy=1, ALU_enable=1, rollback=0 and squash=0.
- Register-register ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU) use Vj op Vk.
- Immediate forms (ADDI, ANDI, ORI, XORI, SLLI, SRLI, SRAI, SLTI, SLTIU) use Vj op imm.
- Shift amount is the low 5 bits of operand 2. SRA/SRAI are arithmetic.
- SLT/SLTI compare signed; SLTU/SLTIU compare unsigned. Result is 0 or 1.
- All arithmetic is modulo 2^32.
- LUI: result = imm.
- AUIPC: result = pc + imm.
- JAL: result = pc + 4; target = pc + imm; jump = 1.
- JALR: result = pc + 4; target = (Vj + imm) & ~1; jump = 1.
- BEQ/BNE/BLT/BGE/BLTU/BGEU:
  - jump = condition on Vj, Vk (BLT/BGE signed, BLTU/BGEU unsigned).
  - target = pc + imm if taken, else pc + 4.
  - result = 0.
- All non-control ops: jump = 0, target = pc + 4.
- Undefined op: result 0, jump 0, target pc + 4; still broadcast so the ROB entry is not lost.
- Squash flag (1 bit):
  - Set on any rdy cycle with rollback=1.
  - Cleared on the next rdy cycle with rollback=0.
  - Purpose: the RS does not update ALU_enable during its rollback cycle, so the following cycle still carries a pre-rollback op. That op must be dropped.

## Timing
- Latency: an op accepted at edge t appears on the outputs after edge t and is held until edge t+1.
- B_ALU_valid is a single-cycle pulse per op. Back-to-back ops give back-to-back pulses.
- Output update per rdy edge:
  - Accepted op: B_ALU_valid <= 1, and all output fields are loaded.
  - Otherwise: B_ALU_valid <= 0; data outputs may hold their old values.
- rdy=0: no state changes. Outputs and squash hold exactly; a held B_ALU_valid=1 stays high, because consumers are also frozen.
- Reset (async, immediate): B_ALU_valid=0, B_ALU_result=0, B_ALU_rdTag=0, ALU_jump=0, ALU_target=0, squash=0.
- Reset asserted mid-broadcast kills the pulse immediately.
- rollback at edge t:
  - B_ALU_valid=0 after t, even if ALU_enable=1.
  - squash=1, so ALU_enable at edge t+1 is ignored.
  - A new dispatch is accepted from edge t+2.
- rollback on consecutive cycles keeps squash set. Acceptance resumes two rdy edges after the last rollback.
- Critical path: 32-bit add/compare plus result mux, within one cycle.

## Test plan
- ADD back-to-back:
  - Stimulus: ADD Vj=7, Vk=5, tag 3 at edge 1; SUB Vj=0, Vk=1, tag 4 at edge 2.
  - Required: valid high two cycles; results 12 then 0xFFFFFFFF; tags 3, 4; jump 0.
- Shifts and compares:
  - SRA Vj=0x80000000, Vk=0x24 → 0xF8000000 (shamt 4).
  - SLTU Vj=1, Vk=0xFFFFFFFF → 1.
  - SLT same operands → 0.
- Control:
  - BLT Vj=-1, Vk=0, pc=0x100, imm=0x20 → jump 1, target 0x120, result 0.
  - BGEU same operands → jump 1 (0xFFFFFFFF ≥ 0).
  - JALR Vj=0x1001, imm=2, pc=0x40 → result 0x44, target 0x1002.
- Rollback squash:
  - Stimulus: ALU_enable held 1 with tag 5 across edges t, t+1, t+2; rollback=1 only at t.
  - Required: valid 0 after t and after t+1; valid 1 with tag 5 after t+2.
- rdy stall:
  - Stimulus: op accepted at edge 1, then rdy=0 for 3 cycles.
  - Required: valid, result and tag held constant; no second pulse after rdy returns unless a new ALU_enable is present.
- Async reset:
  - Stimulus: assert rst between edges while valid=1.
  - Required: all outputs 0 before the next edge; rollback-style squash not set; first op after reset release is accepted.
